// File: rtl/adpll_pkg.sv
// Shared ADPLL controller definitions: FSM state encoding and counter-width helper.
package adpll_pkg;

    typedef enum logic [1:0] {
        ST_INIT   = 2'd0,
        ST_SETTLE = 2'd1,
        ST_ACQ    = 2'd2,
        ST_LOCKED = 2'd3
    } adpll_state_e;

    // Bits needed to hold 0..value-1; never less than 1 so degenerate counters stay legal.
    function automatic int unsigned clog2(input int unsigned value);
        int unsigned w;
        int unsigned v;
        w = 0;
        v = (value > 0) ? value - 1 : 0;
        while (v > 0) begin
            w = w + 1;
            v = v >> 1;
        end
        return (w == 0) ? 1 : w;
    endfunction

endpackage

// File: rtl/k_event_window.sv
// Observation window timer plus saturating carry/borrow event counter for the K gain scheduler.
module k_event_window
    import adpll_pkg::*;
#(
    parameter int unsigned WIN_LEN    = 256,
    parameter int unsigned UNLOCK_THR = 32,
    localparam int unsigned EW        = clog2(UNLOCK_THR + 1)
) (
    input  logic          k_clk,
    input  logic          rst,
    input  logic          clear,
    input  logic          carry,
    input  logic          borrow,
    output logic          win_end_c,
    output logic [EW-1:0] total_c
);

    localparam int unsigned    WW       = clog2(WIN_LEN);
    localparam logic [WW-1:0]  WIN_LAST = WW'(WIN_LEN - 1);
    localparam logic [EW-1:0]  EV_SAT   = EW'(UNLOCK_THR);
    localparam logic [EW:0]    SUM_SAT  = (EW + 1)'(UNLOCK_THR);

    logic [WW-1:0] win_cnt;
    logic [EW-1:0] ev_cnt;
    logic [EW:0]   ev_sum_c;

    // Running total including this cycle's events, so the window-end cycle is counted.
    always_comb begin
        ev_sum_c  = {1'b0, ev_cnt} + (EW + 1)'(carry) + (EW + 1)'(borrow);
        total_c   = (ev_sum_c >= SUM_SAT) ? EV_SAT : ev_sum_c[EW-1:0];
        win_end_c = !clear && (win_cnt == WIN_LAST);
    end

    always_ff @(posedge k_clk) begin
        if (!rst) begin
            win_cnt <= '0;
            ev_cnt  <= '0;
        end else if (clear || win_end_c) begin
            win_cnt <= '0;
            ev_cnt  <= '0;
        end else begin
            win_cnt <= win_cnt + WW'(1);
            ev_cnt  <= total_c;
        end
    end

endmodule

// File: rtl/k_gain_scheduler.sv
// ADPLL K-counter loop-gain scheduler: gear-shifts the modulus exponent from correction
// density per window and reports lock / loss of lock.
module k_gain_scheduler
    import adpll_pkg::*;
#(
    parameter int unsigned KW         = 4,
    parameter int unsigned KMIN       = 2,
    parameter int unsigned KMAX       = 8,
    parameter int unsigned WIN_LEN    = 256,
    parameter int unsigned LOCK_THR   = 4,
    parameter int unsigned UNLOCK_THR = 32,
    parameter int unsigned LOCK_WINS  = 4,
    parameter int unsigned SETTLE_LEN = 16
) (
    input  logic          k_clk,
    input  logic          rst,
    input  logic          carry,
    input  logic          borrow,
    input  logic          force_acq,
    output logic [KW-1:0] k_exp,
    output logic          k_reload,
    output logic          locked,
    output logic          lost
);

    localparam int unsigned   EW          = clog2(UNLOCK_THR + 1);
    localparam int unsigned   QW          = clog2(LOCK_WINS + 1);
    localparam int unsigned   SW          = clog2(SETTLE_LEN);
    localparam logic [KW-1:0] K_LO        = KW'(KMIN);
    localparam logic [KW-1:0] K_HI        = KW'(KMAX);
    localparam logic [QW-1:0] QUIET_LAST  = QW'(LOCK_WINS - 1);
    localparam logic [SW-1:0] SETTLE_LAST = SW'(SETTLE_LEN - 1);
    localparam logic [EW-1:0] QUIET_MAX   = EW'(LOCK_THR);
    localparam logic [EW-1:0] NOISY_MIN   = EW'(UNLOCK_THR);

    adpll_state_e  state, state_d;
    logic [KW-1:0] k_exp_d;
    logic          k_reload_d;
    logic          locked_d;
    logic          lost_d;
    logic [QW-1:0] quiet_cnt, quiet_cnt_d;
    logic [SW-1:0] settle_cnt, settle_cnt_d;

    logic          win_clear_c;
    logic          win_end_c;
    logic [EW-1:0] total_c;
    logic          quiet_c;
    logic          noisy_c;

    assign win_clear_c = (state == ST_INIT) || (state == ST_SETTLE);
    assign quiet_c     = (total_c <= QUIET_MAX);
    assign noisy_c     = (total_c >= NOISY_MIN);

    k_event_window #(
        .WIN_LEN    (WIN_LEN),
        .UNLOCK_THR (UNLOCK_THR)
    ) u_window (
        .k_clk     (k_clk),
        .rst       (rst),
        .clear     (win_clear_c),
        .carry     (carry),
        .borrow    (borrow),
        .win_end_c (win_end_c),
        .total_c   (total_c)
    );

    // Next state and next values of every registered output.
    always_comb begin
        state_d      = state;
        k_exp_d      = k_exp;
        k_reload_d   = 1'b0;
        locked_d     = locked;
        lost_d       = 1'b0;
        quiet_cnt_d  = quiet_cnt;
        settle_cnt_d = settle_cnt;

        case (state)
            ST_INIT: begin
                state_d      = ST_SETTLE;
                k_reload_d   = 1'b1;
                settle_cnt_d = '0;
            end
            ST_SETTLE: begin
                if (settle_cnt == SETTLE_LAST) begin
                    state_d      = ST_ACQ;
                    settle_cnt_d = '0;
                end else begin
                    settle_cnt_d = settle_cnt + SW'(1);
                end
            end
            ST_ACQ: begin
                if (win_end_c) begin
                    if (noisy_c) begin
                        quiet_cnt_d = '0;
                        if (k_exp > K_LO) begin
                            k_exp_d      = k_exp - KW'(1);
                            state_d      = ST_SETTLE;
                            k_reload_d   = 1'b1;
                            settle_cnt_d = '0;
                        end
                    end else if (quiet_c) begin
                        if (quiet_cnt == QUIET_LAST) begin
                            quiet_cnt_d = '0;
                            if (k_exp < K_HI) begin
                                k_exp_d      = k_exp + KW'(1);
                                state_d      = ST_SETTLE;
                                k_reload_d   = 1'b1;
                                settle_cnt_d = '0;
                            end else begin
                                state_d  = ST_LOCKED;
                                locked_d = 1'b1;
                            end
                        end else begin
                            quiet_cnt_d = quiet_cnt + QW'(1);
                        end
                    end else begin
                        quiet_cnt_d = '0;
                    end
                end
            end
            ST_LOCKED: begin
                if (win_end_c && noisy_c) begin
                    k_exp_d      = K_LO;
                    lost_d       = 1'b1;
                    locked_d     = 1'b0;
                    state_d      = ST_SETTLE;
                    k_reload_d   = 1'b1;
                    settle_cnt_d = '0;
                end
            end
            default: begin
                state_d = ST_INIT;
            end
        endcase

        // Forced restart overrides any window decision taken this cycle.
        if (force_acq && (state != ST_INIT)) begin
            state_d      = ST_SETTLE;
            k_exp_d      = K_LO;
            k_reload_d   = 1'b1;
            locked_d     = 1'b0;
            lost_d       = (state == ST_LOCKED);
            quiet_cnt_d  = '0;
            settle_cnt_d = '0;
        end
    end

    always_ff @(posedge k_clk) begin
        if (!rst) begin
            state      <= ST_INIT;
            k_exp      <= K_LO;
            k_reload   <= 1'b0;
            locked     <= 1'b0;
            lost       <= 1'b0;
            quiet_cnt  <= '0;
            settle_cnt <= '0;
        end else begin
            state      <= state_d;
            k_exp      <= k_exp_d;
            k_reload   <= k_reload_d;
            locked     <= locked_d;
            lost       <= lost_d;
            quiet_cnt  <= quiet_cnt_d;
            settle_cnt <= settle_cnt_d;
        end
    end

endmodule

// File: tb/tb_k_gain_scheduler.sv
// Directed bench for k_gain_scheduler with hand-computed timing (settle 16, window 256).
module tb_k_gain_scheduler;

    logic       k_clk     = 1'b0;
    logic       rst       = 1'b0;
    logic       carry     = 1'b0;
    logic       borrow    = 1'b0;
    logic       force_acq = 1'b0;
    logic [3:0] k_exp;
    logic       k_reload;
    logic       locked;
    logic       lost;

    int n_checks = 0;
    int n_errors = 0;
    int cyc      = 0;
    int reloads  = 0;
    int pat      = 0;   // 0: inputs driven by hand, 1: carry every 4th cycle
    int n;

    k_gain_scheduler dut (
        .k_clk     (k_clk),
        .rst       (rst),
        .carry     (carry),
        .borrow    (borrow),
        .force_acq (force_acq),
        .k_exp     (k_exp),
        .k_reload  (k_reload),
        .locked    (locked),
        .lost      (lost)
    );

    always #5 k_clk = ~k_clk;

    task automatic check(input string tag, input int got, input int exp);
        n_checks++;
        if (got != exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // One clock; outputs sampled 1 time unit after the edge, pattern inputs updated.
    task automatic tick();
        @(posedge k_clk);
        #1;
        cyc++;
        if (k_reload === 1'b1) reloads++;
        if (pat == 1) begin
            carry  = (cyc % 4 == 0);
            borrow = 1'b0;
        end
    endtask

    // Ticks until the selected output is high or the budget runs out; n = ticks used.
    task automatic wait_sig(input int sel, input int maxc, output int cnt);
        logic hit;
        cnt = 0;
        do begin
            tick();
            cnt++;
            case (sel)
                0:       hit = k_reload;
                1:       hit = locked;
                default: hit = lost;
            endcase
        end while (hit !== 1'b1 && cnt < maxc);
    endtask

    task automatic run_settle(input int ev);
        for (int i = 0; i < 16; i++) begin
            carry  = (i < ev);
            borrow = 1'b0;
            tick();
        end
        carry = 1'b0;
    endtask

    // One aligned window: n_single carries at the start, optionally carry+borrow in the last cycle.
    task automatic drive_win(input int n_single, input bit last_both);
        for (int i = 0; i < 256; i++) begin
            carry  = (i < n_single) || (last_both && i == 255);
            borrow = last_both && (i == 255);
            tick();
        end
        carry  = 1'b0;
        borrow = 1'b0;
    endtask

    initial begin
        // Reset and INIT
        repeat (3) tick();
        check("rst_k_exp", k_exp, 2);
        check("rst_reload", k_reload, 0);
        check("rst_locked", locked, 0);
        check("rst_lost", lost, 0);
        rst = 1'b1;
        tick();
        check("init_reload", k_reload, 1);
        check("init_k_exp", k_exp, 2);
        tick();
        check("reload_one_cycle", k_reload, 0);

        // Quiet acquisition 2 -> 8, then lock
        wait_sig(0, 1200, n);
        check("acq_step_time", n, 1039);
        check("acq_k_exp", k_exp, 3);
        for (int k = 4; k <= 8; k++) begin
            wait_sig(0, 1200, n);
            check("acq_step_time", n, 1040);
            check("acq_k_exp", k_exp, k);
        end
        check("acq_reload_count", reloads, 7);
        wait_sig(1, 1200, n);
        check("lock_time", n, 1040);
        check("lock_no_reload", k_reload, 0);
        check("lock_k_exp", k_exp, 8);

        // Loss of lock: 16 cycles of carry+borrow = 32 events
        carry  = 1'b1;
        borrow = 1'b1;
        repeat (16) tick();
        carry  = 1'b0;
        borrow = 1'b0;
        wait_sig(2, 400, n);
        check("lost_time", n, 240);
        check("lost_locked", locked, 0);
        check("lost_k_exp", k_exp, 2);
        check("lost_reload", k_reload, 1);
        tick();
        check("lost_one_cycle", lost, 0);
        check("lost_reload_one_cycle", k_reload, 0);

        // Noisy windows at KMIN: no change, no reload
        pat = 1;
        wait_sig(0, 600, n);
        check("kmin_noisy_no_reload", n, 600);
        check("kmin_noisy_k_exp", k_exp, 2);
        pat   = 0;
        carry = 1'b0;
        wait_sig(0, 3000, n);
        check("reacq_k_exp", k_exp, 3);
        wait_sig(0, 1200, n);
        check("reacq_time_4", n, 1040);
        wait_sig(0, 1200, n);
        check("reacq_time_5", n, 1040);
        check("reacq_k_exp_5", k_exp, 5);

        // Noisy step-down at k_exp=5: 64 events in the first window
        pat = 1;
        wait_sig(0, 400, n);
        pat   = 0;
        carry = 1'b0;
        check("noisy_down_time", n, 272);
        check("noisy_down_k_exp", k_exp, 4);

        // Settle events ignored; 4 events (incl. carry+borrow in last cycle) is quiet
        run_settle(8);
        repeat (4) drive_win(2, 1'b1);
        check("quiet4_reload", k_reload, 1);
        check("quiet4_k_exp", k_exp, 5);

        // 5 events is neutral and restarts the quiet count
        run_settle(0);
        repeat (3) drive_win(2, 1'b1);
        drive_win(3, 1'b1);
        check("neutral_no_reload", k_reload, 0);
        check("neutral_k_exp", k_exp, 5);
        repeat (4) drive_win(2, 1'b1);
        check("after_neutral_reload", k_reload, 1);
        check("after_neutral_k_exp", k_exp, 6);

        // Back to LOCKED
        for (int k = 7; k <= 8; k++) begin
            run_settle(0);
            repeat (4) drive_win(0, 1'b0);
            check("relock_step_k_exp", k_exp, k);
        end
        run_settle(0);
        repeat (4) drive_win(0, 1'b0);
        check("relock_locked", locked, 1);

        // force_acq coincident with a noisy window end in LOCKED
        for (int i = 0; i < 256; i++) begin
            carry     = (i < 16);
            borrow    = (i < 16);
            force_acq = (i == 255);
            tick();
        end
        carry     = 1'b0;
        borrow    = 1'b0;
        force_acq = 1'b0;
        check("force_lost", lost, 1);
        check("force_k_exp", k_exp, 2);
        check("force_reload", k_reload, 1);
        check("force_locked", locked, 0);
        tick();
        check("force_lost_one_cycle", lost, 0);
        wait_sig(0, 1200, n);
        check("force_reacq_time", n, 1039);
        check("force_reacq_k_exp", k_exp, 3);

        // force_acq in ACQ: restart without a lost pulse
        repeat (20) tick();
        force_acq = 1'b1;
        tick();
        force_acq = 1'b0;
        check("force_acq_reload", k_reload, 1);
        check("force_acq_k_exp", k_exp, 2);
        check("force_acq_no_lost", lost, 0);
        wait_sig(0, 1200, n);
        check("force_acq_reacq_time", n, 1040);
        check("force_acq_reacq_k_exp", k_exp, 3);

        // Reset in the middle of SETTLE
        repeat (5) tick();
        rst = 1'b0;
        tick();
        check("midrst_k_exp", k_exp, 2);
        check("midrst_reload", k_reload, 0);
        check("midrst_locked", locked, 0);
        check("midrst_lost", lost, 0);
        tick();
        rst = 1'b1;
        tick();
        check("midrst_init_reload", k_reload, 1);
        wait_sig(0, 1200, n);
        check("midrst_reacq_time", n, 1040);
        check("midrst_reacq_k_exp", k_exp, 3);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

    initial begin
        #5000000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "simulation time limit reached");
    end

endmodule
